// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential carry-lookahead adder: FSM state encoding
// and the width of the nibble slice that is time-shared across the operand.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand and result handshake channels of the sequential adder.
// The master drives operands and consumes results; the slave is the adder.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

endinterface

// File: rtl/cla_seq_adder_cla.sv
// 4-bit carry-lookahead adder slice; every carry is formed directly from
// the generate/propagate terms rather than rippling through the bits.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] sum,
  output logic       carry
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] cc;

  assign g = a & b;
  assign p = a ^ b;

  assign cc[0] = c;
  assign cc[1] = g[0] | (p[0] & c);
  assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c);
  assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);

  assign sum   = p ^ cc[3:0];
  assign carry = cc[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract: one 4-bit CLA slice processes a nibble per cycle,
// LSB first, with the carry held in a register between steps.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_seq_adder_if.slave  bus
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
      $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            c_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic            carry_reg;
  logic            ovf_reg;

  logic [CW+1:0]   nib_base;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_sum;
  logic            nib_carry;

  // Counter times four gives the bit offset of the active nibble.
  assign nib_base = {cnt_reg, 2'b00};
  assign nib_a    = a_reg[nib_base +: NIBBLE_W];
  assign nib_b    = b_reg[nib_base +: NIBBLE_W];

  cla u_cla (
    .a     (nib_a),
    .b     (nib_b),
    .c     (c_reg),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      c_reg     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1, so the inversion happens once at capture.
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            c_reg     <= bus.in_sub | bus.in_cin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[nib_base +: NIBBLE_W] <= nib_sum;
          c_reg <= nib_carry;
          if (cnt_reg == LAST) begin
            carry_reg <= nib_carry;
            ovf_reg   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (nib_sum[3] != a_reg[WIDTH-1]);
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_sum   = sum_reg;
  assign bus.out_carry = carry_reg;
  assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed test of cla_seq_adder at WIDTH=16: add, carry ripple, subtract,
// signed overflow, output backpressure and asynchronous reset during RUN.
module tb_cla_seq_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cla_seq_adder_if #(.WIDTH(16)) bus ();

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; returns result, cycles from accept to out_valid,
  // and whether in_ready stayed low while the op was in flight.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input bit handshake,
                        output logic [15:0] s, output logic c, output logic o,
                        output int lat, output bit ir_low);
    int n;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_cin = cin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      s = '0; c = 1'b0; o = 1'b0; lat = -1; ir_low = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    ir_low = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) ir_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.in_ready) ir_low = 1'b0;
    s = bus.out_sum; c = bus.out_carry; o = bus.out_ovf;
    $display("op a=%h b=%h sub=%0d cin=%0d -> sum=%h carry=%0d ovf=%0d lat=%0d",
             a, b, sub, cin, s, c, o, lat);
    if (handshake && bus.out_valid) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.out_sum, bus.out_carry, bus.out_ovf} !== 18'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got sum=%h c=%b o=%b, want 0", bus.out_sum, bus.out_carry, bus.out_ovf);
    end
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b, want 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_add();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h5555, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL add_basic: got %h/%b/%b, want 5555/0/0", s, c, o);
    end
    n_checks++;
    if (lat !== 4) begin
      n_errors++;
      $display("FAIL add_latency: got %0d, want 4", lat);
    end
    n_checks++;
    if (ir_low !== 1'b1) begin
      n_errors++;
      $display("FAIL add_in_ready_low: got %b, want 1", ir_low);
    end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL carry_ripple: got %h/%b/%b, want 0000/1/0", s, c, o);
    end
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL carry_cin: got %h/%b/%b, want 0000/1/0", s, c, o);
    end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL sub_borrow: got %h/%b/%b, want fffe/0/0", s, c, o);
    end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL sub_ovf: got %h/%b/%b, want 7fff/1/1", s, c, o);
    end
  endtask

  task automatic test_ovf();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h8000, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL add_ovf: got %h/%b/%b, want 8000/0/1", s, c, o);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    bit stable;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, s, c, o, lat, ir_low);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.in_a = 16'(i * 16'h1111);
      bus.in_b = 16'hABCD;
      bus.in_sub = i[1];
      @(posedge clk);
      #1;
      if ({bus.out_sum, bus.out_carry, bus.out_ovf} !== {16'h5555, 1'b0, 1'b0} ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    $display("backpressure held 10 cycles, stable=%0d", stable);
    n_checks++;
    if (stable !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_stable: got %b, want 1 (sum=%h rdy=%b vld=%b)", stable, bus.out_sum, bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL bp_release: got rdy/vld/busy=%b, want 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
    n_checks++;
    if (bus.out_sum !== 16'h5555) begin
      n_errors++;
      $display("FAIL bp_hold_sum: got %h, want 5555", bus.out_sum);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h0002, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL bp_next_op: got %h/%b/%b, want 0002/0/0", s, c, o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s; logic c, o; int lat; bit ir_low;
    // Prior result leaves 0x8000 in the sum register, so a missed clear is visible.
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    @(negedge clk);
    bus.in_a = 16'hFFFF; bus.in_b = 16'h0001; bus.in_sub = 1'b0; bus.in_cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-run: sum=%h rdy=%b busy=%b", bus.out_sum, bus.in_ready, bus.busy);
    n_checks++;
    if ({bus.out_sum, bus.out_carry, bus.out_ovf} !== 18'h0) begin
      n_errors++;
      $display("FAIL midrun_reset_outputs: got %h/%b/%b, want 0000/0/0", bus.out_sum, bus.out_carry, bus.out_ovf);
    end
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL midrun_reset_flags: got rdy/vld/busy=%b, want 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat, ir_low);
    n_checks++;
    if ({s, c, o} !== {16'h0100, 1'b0, 1'b0} || lat !== 4) begin
      n_errors++;
      $display("FAIL after_reset_op: got %h/%b/%b lat=%0d, want 0100/0/0 lat=4", s, c, o, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sub = 1'b0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_ovf();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-precision adder/subtractor controller that time-shares one 4-bit carry-lookahead adder nibble slice.
- Adds or subtracts WIDTH-bit operands one nibble per cycle, LSB nibble first, chaining the carry through a register.
- Operands arrive on a valid/ready input channel; results leave on a valid/ready output channel.
- Serves as the area-cheap wide adder for datapaths that do not need single-cycle WIDTH-bit addition.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/command valid
- in_ready  output  1  block can accept an operation
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  1 = A - B, 0 = A + B
- in_cin  input  1  carry-in for add; ignored when in_sub=1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_carry  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  two's-complement signed overflow
- busy  output  1  state is not IDLE

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- FSM has three states: IDLE, RUN, DONE.
- Reset (rst_n low, any state, including mid-RUN):
  - State goes to IDLE.
  - Counter, carry register and operand registers clear to 0.
  - out_sum=0, out_carry=0, out_ovf=0, out_valid=0, busy=0.
  - in_ready=1 once in IDLE.
  - Any in-flight operation is discarded.
- Output decodes: in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - On the in_valid & in_ready edge, capture a_r=in_a, b_r = in_sub ? ~in_b : in_b, and c_r = in_sub ? 1 : in_cin.
  - Clear the step counter and go to RUN.
- RUN, step k = 0..NIB-1:
  - cla inputs are a_r[4k+3:4k], b_r[4k+3:4k] and c_r.
  - Nibble k of the sum register takes the cla sum; c_r takes the cla carry.
  - When k==NIB-1: out_carry takes the final carry, out_ovf is computed, and the state goes to DONE.
  - Otherwise k increments.
  - in_valid is ignored.
- Overflow: out_ovf = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]), evaluated on the final-step result.
- DONE:
  - out_* stay stable while out_ready=0, for any duration.
  - On out_valid & out_ready, go to IDLE; out_sum, out_carry and out_ovf hold their last values.
- Latency: if the accept edge is T, out_valid is high after edge T+NIB (4 edges for WIDTH=16).
- No overlap. A new op is accepted no earlier than the cycle after the result handshake. Throughput is one op per NIB+2 cycles.
- Counter width is max(1, clog2(NIB)). NIB=1 (WIDTH=4) is legal: RUN lasts exactly one cycle.
- Width rules: all arithmetic is modulo 2^WIDTH. There is no sign extension; signedness only affects out_ovf.

Decomposition:
- Shared package cla_seq_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the nibble width constant (4).
- One sub-module: the existing 4-bit carry-lookahead adder cla, instantiated once (ports a[3:0], b[3:0], c, sum[3:0], carry).
- The controller, operand/result registers and counter live in cla_seq_adder.
- The shift/select of nibble k is a mux on the counter; no shifting of operand registers is required.

Test Plan:
- Add 0x1234 + 0x4321, cin=0: out_sum=0x5555, carry=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- Carry ripple: 0xFFFF + 0x0001 gives 0x0000, carry=1, ovf=0. Separately, 0xFFFF + 0x0000 with cin=1 gives 0x0000, carry=1.
- Subtract:
  - 0x0005 - 0x0007 (in_cin=0, ignored) gives 0xFFFE, carry=0, ovf=0.
  - 0x8000 - 0x0001 gives 0x7FFF, carry=1, ovf=1.
- Signed overflow on add: 0x7FFF + 0x0001 gives 0x8000, carry=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid with new operands. Required response:
  - out_sum, out_carry and out_ovf stay constant;
  - in_ready stays 0 and no new op is captured;
  - after out_ready=1 for one cycle, in_ready=1 on the next cycle;
  - the next op (0x0001 + 0x0001) gives 0x0002.
- Reset mid-RUN: assert rst_n low after step 2 of 0xFFFF + 0x0001. All outputs go to 0 immediately (asynchronously) with in_ready=1. After release, 0x00FF + 0x0001 gives 0x0100, carry=0.
